// File: rtl/sobel_pkg.sv
// sobel_pkg: shared sizes, sequencer states and result tag
// for the Sobel frame sequencer.
package sobel_pkg;

  localparam int LINE_WIDTH    = 64;
  localparam int PIX_PER_BEAT  = 8;
  localparam int BEATS_PER_ROW = LINE_WIDTH / PIX_PER_BEAT;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PRIME,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [15:0] row;
    logic [7:0]  beat;
  } res_tag_t;

endpackage

// File: rtl/sobel_frame_sequencer_if.sv
// sobel_frame_sequencer_if: control, pixel-in, datapath and
// result-out signals of the Sobel frame sequencer.
interface sobel_frame_sequencer_if;

  logic        start;
  logic        busy;
  logic        frame_done;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        sob_reset_n;
  logic        sob_clock_en;
  logic [31:0] sob_dataa;
  logic [31:0] sob_datab;
  logic [31:0] sob_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_row;
  logic [7:0]  out_beat;

  modport master (
    input  start,
    output busy,
    output frame_done,
    input  in_valid,
    output in_ready,
    input  in_data,
    output sob_reset_n,
    output sob_clock_en,
    output sob_dataa,
    output sob_datab,
    input  sob_result,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_row,
    output out_beat
  );

  modport slave (
    output start,
    input  busy,
    input  frame_done,
    output in_valid,
    input  in_ready,
    output in_data,
    input  sob_reset_n,
    input  sob_clock_en,
    input  sob_dataa,
    input  sob_datab,
    output sob_result,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_row,
    input  out_beat
  );

endinterface

// File: rtl/sobel_seq_out_fifo.sv
// sobel_seq_out_fifo: 2-entry result+tag FIFO that decouples
// the non-stallable datapath from output backpressure.
module sobel_seq_out_fifo
  import sobel_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  res_tag_t    push_tag,
  input  logic        pop,
  output logic [31:0] head_data,
  output res_tag_t    head_tag,
  output logic [1:0]  count
);

  logic [31:0] data_q [2];
  res_tag_t    tag_q  [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // storage, written at the tail
  always_ff @(posedge clock) begin
    if (do_push) begin
      data_q[wr_ptr] <= push_data;
      tag_q[wr_ptr]  <= push_tag;
    end
  end

  // pointers and occupancy; push+pop together keeps count
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_tag  = tag_q[rd_ptr];

endmodule

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: streams one frame of 8-px beats through
// the Sobel datapath. Define SOBEL_SEQ_PERF_EN for perf counters.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int NUM_ROWS = 64
) (
  input  logic clock,
  input  logic reset,
  sobel_frame_sequencer_if.master bus
`ifdef SOBEL_SEQ_PERF_EN
  ,
  output logic [31:0] perf_frame_cycles,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam logic [7:0]  LAST_BEAT = 8'(BEATS_PER_ROW - 1);
  localparam logic [15:0] LAST_ROW  = 16'(NUM_ROWS - 1);

  seq_state_t  state;
  seq_state_t  state_nx;
  logic [15:0] row;
  logic [7:0]  beat;
  logic        pend;
  logic        pend_push;
  res_tag_t    pend_tag;
  logic [1:0]  fifo_count;
  logic [31:0] head_data;
  res_tag_t    head_tag;
  logic        rdy;
  logic        work;
  logic        busy;
  logic        frame_done;
  logic        issue;
  logic        row_end;
  logic        start_acc;
  logic        out_vld;
  logic        pop;
  logic        fifo_last;

  assign start_acc = bus.start && (state == IDLE);
  assign out_vld   = fifo_count != 2'd0;
  assign pop       = out_vld && bus.out_ready;
  assign issue     = bus.in_valid && rdy;
  assign row_end   = issue && (beat == LAST_BEAT);
  assign fifo_last = (fifo_count == 2'd0)
                  || ((fifo_count == 2'd1) && pop);

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state: drain ends the cycle the last result leaves
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = CLEAR;
      CLEAR: state_nx = PRIME;
      PRIME: if (row_end && row == 16'd1) state_nx = RUN;
      RUN:   if (row_end && row == LAST_ROW) state_nx = DRAIN;
      DRAIN: if (!pend && fifo_last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs; RUN credits a same-cycle pop so 1 beat/cycle holds
  always_comb begin
    rdy        = 1'b0;
    work       = 1'b0;
    busy       = state != IDLE;
    frame_done = state == DONE;
    unique case (state)
      PRIME: begin
        rdy  = 1'b1;
        work = 1'b1;
      end
      RUN: begin
        work = 1'b1;
        rdy  = ({1'b0, fifo_count} + {2'b00, pend})
             < (3'd2 + {2'b00, pop});
      end
      default: ;
    endcase
  end

  // row/beat position of the next accepted beat
  always_ff @(posedge clock) begin
    if (reset || start_acc) begin
      row  <= 16'd0;
      beat <= 8'd0;
    end else if (issue) begin
      if (beat == LAST_BEAT) begin
        beat <= 8'd0;
        row  <= (row == LAST_ROW) ? 16'd0 : row + 16'd1;
      end else begin
        beat <= beat + 8'd1;
      end
    end
  end

  // beat in flight through the datapath and its output tag
  always_ff @(posedge clock) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_push <= 1'b0;
      pend_tag  <= '0;
    end else begin
      pend      <= issue;
      pend_push <= issue && (state == RUN);
      if (issue) begin
        pend_tag.row  <= row - 16'd1;
        pend_tag.beat <= beat;
      end
    end
  end

  // datapath reset: low in reset and the cycle after a start
  always_ff @(posedge clock) begin
    if (reset) bus.sob_reset_n <= 1'b0;
    else       bus.sob_reset_n <= ~start_acc;
  end

  sobel_seq_out_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pend_push),
    .push_data (bus.sob_result),
    .push_tag  (pend_tag),
    .pop       (pop),
    .head_data (head_data),
    .head_tag  (head_tag),
    .count     (fifo_count)
  );

  assign bus.busy         = busy;
  assign bus.frame_done   = frame_done;
  assign bus.in_ready     = rdy;
  assign bus.sob_clock_en = issue;
  assign bus.sob_dataa    = bus.in_data[31:0];
  assign bus.sob_datab    = bus.in_data[63:32];
  assign bus.out_valid    = out_vld;
  assign bus.out_data     = head_data;
  assign bus.out_row      = head_tag.row;
  assign bus.out_beat     = head_tag.beat;

`ifdef SOBEL_SEQ_PERF_EN
  // frame length and input stall cycles, held after DONE
  always_ff @(posedge clock) begin
    if (reset || start_acc) begin
      perf_frame_cycles <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (state inside {CLEAR, PRIME, RUN, DRAIN})
        perf_frame_cycles <= perf_frame_cycles + 32'd1;
      if (work && bus.in_valid && !rdy)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: table vectors, directed corner cases
// and random frames checked against a frame-level result model.
module tb_sobel_frame_sequencer;
  import sobel_pkg::*;

  localparam int NR     = 64;
  localparam int BPR    = BEATS_PER_ROW;
  localparam int NBEATS = NR * BPR;
  localparam int NRES   = (NR - 2) * BPR;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] row;
    logic [7:0]  beat;
  } res_t;

  typedef struct {
    logic        vld;
    logic [63:0] data;
    logic        exp_en;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sobel_frame_sequencer_if bus ();

`ifdef SOBEL_SEQ_PERF_EN
  logic [31:0] pf;
  logic [31:0] ps;
`endif

  sobel_frame_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef SOBEL_SEQ_PERF_EN
    ,
    .perf_frame_cycles (pf),
    .perf_stall_cycles (ps)
`endif
  );

  res_t exp_q[$];
  res_t mon_got;
  res_t first_res;
  res_t last_res;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   issue_k = 0;
  int   en_cnt = 0;
  int   pop_cnt = 0;
  int   stall_cnt = 0;
  int   last_pop_cyc = -10;
  int   rdy_mode = 0;
  bit   sb_on = 1'b0;

  function automatic logic [31:0] hash(int k);
    return 32'(k) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // datapath stand-in: result of the k-th issued beat is hash(k)
  initial bus.sob_result = 32'd0;
  always @(posedge clock) begin
    if (!bus.sob_reset_n) begin
      issue_k <= 0;
    end else if (bus.sob_clock_en) begin
      bus.sob_result <= hash(issue_k);
      issue_k <= issue_k + 1;
    end
  end

  // consumer
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // monitor and scoreboard, sampled mid-cycle
  always @(negedge clock) begin
    if (bus.sob_clock_en) en_cnt++;
    if (bus.in_valid && !bus.in_ready) stall_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      mon_got = {bus.out_data, bus.out_row, bus.out_beat};
      if (pop_cnt == 0) first_res = mon_got;
      last_res = mon_got;
      pop_cnt++;
      last_pop_cyc = cyc;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got %h want none", mon_got);
        end else begin
          chk("sb_pop", mon_got, exp_q.pop_front());
        end
      end
    end
  end

  task automatic build_exp();
    exp_q.delete();
    for (int k = 0; k < NBEATS; k++)
      if (k / BPR >= 2)
        exp_q.push_back({hash(k), 16'(k / BPR - 1),
                         8'(k % BPR)});
  endtask

  task automatic start_frame(output int clr);
    build_exp();
    en_cnt = 0;
    pop_cnt = 0;
    stall_cnt = 0;
    sb_on = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    clr = cyc;
    chk("clear_cycle", {bus.busy, bus.sob_reset_n, bus.in_ready},
        3'b100);
    tick();
    chk("prime_entry", {bus.sob_reset_n, bus.in_ready}, 2'b11);
  endtask

  task automatic stream(int n, int pct, string tag);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 20000) begin
      bus.in_valid = (pct >= 100) || ($urandom_range(99) < pct);
      bus.in_data = {$urandom(), $urandom()};
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) got++;
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_beats"}, got, n);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.frame_done) begin
        dc = cyc;
        break;
      end
      tick();
    end
    chk("done_seen", dc >= 0, 1);
  endtask

  task automatic end_checks(string tag, int dc);
    chk({tag, "_pops"}, pop_cnt, NRES);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_done_lat"}, dc, last_pop_cyc + 1);
    tick();
    chk({tag, "_idle"}, {bus.frame_done, bus.busy}, 2'b00);
    sb_on = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    int   clr;
    int   dc;
    int   hs;
    int   nv;
    vt[0] = '{1'b1, 64'h0123_4567_89ab_cdef, 1'b1,
              32'h89ab_cdef, 32'h0123_4567};
    vt[1] = '{1'b0, 64'hffff_ffff_0000_0000, 1'b0,
              32'h0000_0000, 32'hffff_ffff};
    vt[2] = '{1'b1, 64'h0000_0000_0000_0000, 1'b1,
              32'h0000_0000, 32'h0000_0000};
    vt[3] = '{1'b1, 64'hffff_ffff_ffff_ffff, 1'b1,
              32'hffff_ffff, 32'hffff_ffff};
    vt[4] = '{1'b0, 64'hdead_beef_cafe_f00d, 1'b0,
              32'hcafe_f00d, 32'hdead_beef};
    vt[5] = '{1'b1, 64'h8040_2010_0804_0201, 1'b1,
              32'h0804_0201, 32'h8040_2010};

    // reset, with start held high: reset wins
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 64'd0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_outs", {bus.busy, bus.frame_done, bus.in_ready,
        bus.sob_clock_en, bus.out_valid, bus.sob_reset_n}, 6'd0);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("rst_start_drop", {bus.busy, bus.sob_reset_n}, 2'b01);

    // frame A: table in PRIME, full throughput
    rdy_mode = 0;
    start_frame(clr);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = vt[i].vld;
      bus.in_data = vt[i].data;
      #1;
      chk($sformatf("vec%0d_ctl", i),
          {bus.sob_clock_en, bus.in_ready, bus.out_valid},
          {vt[i].exp_en, 2'b10});
      chk($sformatf("vec%0d_data", i),
          {bus.sob_dataa, bus.sob_datab},
          {vt[i].exp_a, vt[i].exp_b});
      if (vt[i].vld) nv++;
      tick();
    end
    bus.in_valid = 1'b0;
    stream(2 * BPR - nv, 100, "primeA");
    repeat (3) tick();
    chk("prime_no_out", {pop_cnt, 31'd0, bus.out_valid}, 64'd0);
    chk("prime_en", en_cnt, 2 * BPR);
    stream(NRES, 100, "runA");
    wait_done(dc);
    chk("first_tag", {first_res.row, first_res.beat},
        {16'd1, 8'd0});
    chk("last_tag", {last_res.row, last_res.beat},
        {16'(NR - 2), 8'(BPR - 1)});
    chk("throughput", (dc - clr) <= NBEATS + 16, 1);
    chk("en_total", en_cnt, NBEATS);
    end_checks("A", dc);

    // frame B: backpressure from the first RUN beat
    rdy_mode = 2;
    start_frame(clr);
    stream(2 * BPR, 100, "primeB");
    hs = 0;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = {$urandom(), $urandom()};
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) hs++;
      tick();
    end
    #1;
    chk("bp_flags", {bus.in_ready, bus.out_valid}, 2'b01);
    chk("bp_hs", hs, 2);
    chk("bp_pops", pop_cnt, 0);
    chk("bp_head0", {bus.out_data, bus.out_row, bus.out_beat},
        exp_q[0]);
    tick();
    chk("bp_head1", {bus.out_data, bus.out_row, bus.out_beat},
        exp_q[0]);
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_ignored",
        {bus.busy, bus.sob_reset_n, bus.out_valid}, 3'b111);
    rdy_mode = 0;
    stream(NBEATS - 2 * BPR - 2, 100, "runB");
    wait_done(dc);
    end_checks("B", dc);

    // frame D: reset at row 5 beat 3 with results buffered
    rdy_mode = 0;
    start_frame(clr);
    stream(5 * BPR + 3, 100, "runD");
    rdy_mode = 2;
    tick();
    tick();
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    chk("mid_rst", {bus.busy, bus.out_valid, bus.sob_reset_n,
        bus.in_ready, bus.frame_done}, 5'd0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    sb_on = 1'b0;
    exp_q.delete();
    tick();
    tick();
    chk("post_rst", {bus.busy, bus.out_valid}, 2'b00);

    // frame C: random valid and ready
    rdy_mode = 1;
    start_frame(clr);
    stream(NBEATS, 60, "runC");
    wait_done(dc);
`ifdef SOBEL_SEQ_PERF_EN
    chk("perf_stall", ps, stall_cnt);
    chk("perf_frame", pf, dc - clr);
`endif
    end_checks("C", dc);
`ifdef SOBEL_SEQ_PERF_EN
    tick();
    tick();
    chk("perf_hold", {ps, pf}, {32'(stall_cnt), 32'(dc - clr)});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
